// File: rtl/mult_issue_queue.sv
// Operand issue queue for the 16x16 shift-add multiplier: buffers operand pairs in a
// FIFO and hands them to the multiplier one at a time with a St/Idle/Done handshake.
module mult_issue_queue #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         In_valid,
    output logic                         In_ready,
    input  logic [W-1:0]                 In_a,
    input  logic [W-1:0]                 In_b,
    output logic [W-1:0]                 Mul_A,
    output logic [W-1:0]                 Mul_B,
    output logic                         Mul_St,
    input  logic                         Mul_Idle,
    input  logic                         Mul_Done,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Busy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    pair_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    // Issue only when the multiplier is idle, so a new St never overlaps an orphan or Done op.
    assign push = In_valid & In_ready;
    assign pop  = (state == S_IDLE) && (Count != '0) && Mul_Idle;

    // Next-state and occupancy.
    always_comb begin
        state_nxt = state;
        count_nxt = Count;
        unique case (state)
            S_IDLE:  if (pop)       state_nxt = S_START;
            S_START: if (!Mul_Idle) state_nxt = S_RUN;
            S_RUN:   if (Mul_Done)  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
        if (push && !pop) begin
            count_nxt = Count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = Count - CW'(1);
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and Count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: In_a, b: In_b};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            In_ready <= 1'b0;
            Mul_A    <= '0;
            Mul_B    <= '0;
            Mul_St   <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            Count    <= count_nxt;
            In_ready <= (count_nxt != CW'(DEPTH));
            Mul_St   <= (state_nxt == S_START);
            Busy     <= (state_nxt != S_IDLE);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Operands held until the next pop: the multiplier re-reads them every add cycle.
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                Mul_A  <= mem[rd_ptr].a;
                Mul_B  <= mem[rd_ptr].b;
            end
        end
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Bench for mult_issue_queue: behavioural shift-add multiplier model plus a product
// scoreboard filled at push time and drained as the model completes operations.
module tb_mult_issue_queue;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          Clk   = 1'b0;
    logic          Rst_n = 1'b1;
    logic          In_valid = 1'b0;
    logic          In_ready;
    logic [W-1:0]  In_a = '0;
    logic [W-1:0]  In_b = '0;
    logic [W-1:0]  Mul_A;
    logic [W-1:0]  Mul_B;
    logic          Mul_St;
    logic          Mul_Idle;
    logic          Mul_Done;
    logic [CW-1:0] Count;
    logic          Busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] act_q [$];

    always #5 Clk = ~Clk;

    mult_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(In_valid), .In_ready(In_ready), .In_a(In_a), .In_b(In_b),
        .Mul_A(Mul_A), .Mul_B(Mul_B), .Mul_St(Mul_St),
        .Mul_Idle(Mul_Idle), .Mul_Done(Mul_Done),
        .Count(Count), .Busy(Busy)
    );

    // Multiplier model: no reset, optional accept stall, re-reads Mul_B on every add cycle.
    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_BUSY, M_DONE} mstate_t;
    mstate_t      mstate = M_IDLE;
    logic [W-1:0] m_a    = '0;
    logic [31:0]  m_acc  = '0;
    int           m_bit  = 0;
    int           m_wait = 0;
    int           stall  = 0;
    logic         force_busy = 1'b0;
    logic         spur_done  = 1'b0;

    assign Mul_Idle = ((mstate == M_IDLE) || (mstate == M_WAIT)) && !force_busy;
    assign Mul_Done = (mstate == M_DONE) || spur_done;

    always @(posedge Clk) begin
        case (mstate)
            M_IDLE: if (Mul_St && !force_busy) begin
                if (stall == 0) begin
                    mstate <= M_BUSY; m_a <= Mul_A; m_acc <= '0; m_bit <= 0;
                end else begin
                    mstate <= M_WAIT; m_wait <= stall - 1;
                end
            end
            M_WAIT: if (m_wait == 0) begin
                mstate <= M_BUSY; m_a <= Mul_A; m_acc <= '0; m_bit <= 0;
            end else begin
                m_wait <= m_wait - 1;
            end
            M_BUSY: begin
                if (m_a[m_bit]) m_acc <= m_acc + (32'(Mul_B) << m_bit);
                m_bit <= m_bit + 1;
                if (m_bit == 15) mstate <= M_DONE;
            end
            default: begin
                act_q.push_back(m_acc);
                mstate <= M_IDLE;
            end
        endcase
    end

    // Offer a pair from a negedge; returns at the negedge after the transfer edge.
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        In_valid = 1'b1; In_a = a; In_b = b;
        while (In_ready !== 1'b1 && guard < 300) begin
            @(negedge Clk); guard++;
        end
        if (In_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL push_timeout: In_ready=%b want 1 for a=%h b=%h", In_ready, a, b);
        end else begin
            exp_q.push_back(32'(a) * 32'(b));
            @(negedge Clk);
        end
        In_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        logic [31:0] got;
        logic [31:0] want;
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            while (act_q.size() == 0 && guard < 400) begin
                @(negedge Clk); guard++;
            end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL result_timeout: no product, want %h", (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end else if (exp_q.size() == 0) begin
                got = act_q.pop_front();
                errors++;
                $display("FAIL result_extra: got %h, want none", got);
            end else begin
                got  = act_q.pop_front();
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result_order: product %h want %h", got, want);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (In_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", In_ready); end
        checks++; if (Count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", Count); end
        checks++; if (Mul_St !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL reset_st_busy: st=%b busy=%b want 0 0", Mul_St, Busy); end
        checks++; if (Mul_A !== '0 || Mul_B !== '0) begin errors++; $display("FAIL reset_operands: a=%h b=%h want 0 0", Mul_A, Mul_B); end
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", In_ready); end
    endtask

    task automatic test_single();
        push_pair(16'd3, 16'd5);
        checks++; if (Count !== CW'(1) || Mul_St !== 1'b0) begin errors++; $display("FAIL single_pushed: count=%0d st=%b want 1 0", Count, Mul_St); end
        @(negedge Clk);
        checks++; if (Mul_St !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL single_issue: st=%b busy=%b want 1 1", Mul_St, Busy); end
        checks++; if (Mul_A !== 16'd3 || Mul_B !== 16'd5) begin errors++; $display("FAIL single_operands: a=%0d b=%0d want 3 5", Mul_A, Mul_B); end
        checks++; if (Count !== CW'(0)) begin errors++; $display("FAIL single_popped: count=%0d want 0", Count); end
        wait_results(1);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: busy=%b want 0", Busy); end
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b1;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(W'(2 * i + 2), W'(2 * i + 3));
        checks++; if (Count !== CW'(4) || In_ready !== 1'b0) begin errors++; $display("FAIL full_flags: count=%0d ready=%b want 4 0", Count, In_ready); end
        In_valid = 1'b1; In_a = 16'd10; In_b = 16'd11;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (In_ready !== 1'b0 || Count !== CW'(4)) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL full_hold: ready=%b count=%0d want 0 4", In_ready, Count); end
        force_busy = 1'b0;
        push_pair(16'd10, 16'd11);
        wait_results(5);
    endtask

    task automatic test_same_cycle();
        force_busy = 1'b1;
        push_pair(16'd7, 16'd9);
        push_pair(16'd12, 16'd13);
        checks++; if (Count !== CW'(2)) begin errors++; $display("FAIL same_pre_count: count=%0d want 2", Count); end
        force_busy = 1'b0;
        In_valid = 1'b1; In_a = 16'd21; In_b = 16'd3;
        checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL same_ready: ready=%b want 1", In_ready); end
        @(negedge Clk);
        exp_q.push_back(32'd63);
        In_valid = 1'b0;
        checks++; if (Count !== CW'(2) || Mul_St !== 1'b1) begin errors++; $display("FAIL same_count: count=%0d st=%b want 2 1", Count, Mul_St); end
        checks++; if (Mul_A !== 16'd7 || Mul_B !== 16'd9) begin errors++; $display("FAIL same_head: a=%0d b=%0d want 7 9", Mul_A, Mul_B); end
        wait_results(3);
    endtask

    task automatic test_stall();
        int guard = 0;
        int n = 0;
        bit ok = 1'b1;
        stall = 1;
        push_pair(16'h1234, 16'h0056);
        while (Mul_St !== 1'b1 && guard < 20) begin @(negedge Clk); guard++; end
        while (Mul_St === 1'b1 && n < 50) begin
            n++;
            if (Mul_A !== 16'h1234 || Mul_B !== 16'h0056) ok = 1'b0;
            @(negedge Clk);
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL stall_st_len: st high %0d cycles want 3", n); end
        guard = 0;
        while (act_q.size() == 0 && guard < 200) begin
            if (Mul_A !== 16'h1234 || Mul_B !== 16'h0056) ok = 1'b0;
            @(negedge Clk); guard++;
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_operand_hold: a=%h b=%h want 1234 0056", Mul_A, Mul_B); end
        wait_results(1);
        stall = 0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        bit ok = 1'b1;
        logic [31:0] orphan;
        push_pair(16'd1, 16'd2);
        push_pair(16'd3, 16'd4);
        push_pair(16'd5, 16'd6);
        push_pair(16'd7, 16'd8);
        checks++; if (Count !== CW'(3) || Busy !== 1'b1) begin errors++; $display("FAIL mid_pre: count=%0d busy=%b want 3 1", Count, Busy); end
        Rst_n = 1'b0;
        #1;
        checks++; if (Count !== CW'(0) || Mul_St !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mid_reset: count=%0d st=%b busy=%b want 0 0 0", Count, Mul_St, Busy); end
        exp_q.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        push_pair(16'd9, 16'd10);
        while (act_q.size() == 0 && guard < 200) begin
            if (Mul_St !== 1'b0) ok = 1'b0;
            @(negedge Clk); guard++;
        end
        checks++; if (!ok || act_q.size() == 0) begin errors++; $display("FAIL mid_orphan_overlap: st_clean=%b orphan_seen=%0d want 1 1", ok, act_q.size()); end
        if (act_q.size() != 0) orphan = act_q.pop_front();
        wait_results(1);
    endtask

    task automatic test_spurious();
        bit ok = 1'b1;
        spur_done = 1'b1;
        @(negedge Clk);
        spur_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (Busy !== 1'b0 || Mul_St !== 1'b0 || Count !== CW'(0)) ok = 1'b0;
            @(negedge Clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL spurious_done: busy=%b st=%b count=%0d want 0 0 0", Busy, Mul_St, Count); end
        push_pair(16'hFFFF, 16'hFFFF);
        wait_results(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_cycle();
        test_stall();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
